// File: rtl/tmds_rx_lane.sv
// -----------------------------------------------------------------------------
// tmds_rx_lane
//
// Purpose:
//   One TMDS receive lane running at the bit clock. Serial bits are shifted
//   into a 10-bit window and a symbol is captured every 10 bit clocks. While
//   hunting, the lane looks for a run of aligned control tokens. Every
//   non-token capture slips the symbol boundary by one bit. Once enough
//   consecutive tokens are seen the lane locks. It then publishes each captured
//   symbol together with its 8-bit data decode and its control decode. A long
//   run of non-control symbols while locked is treated as lost alignment, and
//   the lane returns to hunting.
//
// Parameters:
//   CTRL_RUN      consecutive aligned control tokens needed to lock (2..255)
//   TIMEOUT_SYMS  consecutive non-control symbols that drop lock (2..65535)
//
// Ports:
//   clk_bit    in   bit clock (10x pixel rate), rising edge
//   rst_n_bit  in   asynchronous active-low reset
//   en         in   lane enable; low forces hunting and clears lock
//   sdata      in   serial bit, symbol bit 0 arrives first
//   sym_valid  out  one-cycle strobe for a newly published symbol
//   sym        out  raw aligned 10-bit symbol (bit 0 = first received)
//   data       out  decoded pixel byte
//   ctrl       out  decoded control bits {c1,c0}, updated on tokens only
//   is_ctrl    out  published symbol is one of the four control tokens
//   locked     out  word alignment established
// -----------------------------------------------------------------------------
module tmds_rx_lane #(
    parameter int unsigned CTRL_RUN     = 8,
    parameter int unsigned TIMEOUT_SYMS = 1024
) (
    input  logic       clk_bit,
    input  logic       rst_n_bit,
    input  logic       en,
    input  logic       sdata,
    output logic       sym_valid,
    output logic [9:0] sym,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       is_ctrl,
    output logic       locked
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]  RUN_LIM = 8'(CTRL_RUN);
    localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_SYMS);

    state_t      state_q, state_d;
    logic [9:0]  shreg_q, shreg_d;
    logic [3:0]  phase_q, phase_d;
    logic        slip_q, slip_d;
    logic [7:0]  run_ctr_q, run_ctr_d;
    logic [15:0] to_ctr_q, to_ctr_d;
    logic [9:0]  sym_q, sym_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        is_ctrl_q, is_ctrl_d;
    logic        sym_valid_q, sym_valid_d;

    logic        capture;
    logic        tok_hit;
    logic [1:0]  tok_ctrl;
    logic        publish;
    logic [7:0]  run_inc;
    logic [15:0] to_inc;

    // Returns {hit, c1, c0} for the four control tokens, zero otherwise.
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    // TMDS data decode: undo the optional inversion, then undo the XOR/XNOR
    // chaining selected by bit 8.
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q    = 8'h00;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    // Next-state logic. The captured word is the window after this cycle's
    // shift, so lookups are done on shreg_d rather than shreg_q. A slip is
    // realised by holding phase at 0 for one extra cycle after a rejected
    // capture, which pushes the next capture out to 11 cycles.
    always_comb begin
        shreg_d     = {sdata, shreg_q[9:1]};
        capture     = (phase_q == 4'd9);
        {tok_hit, tok_ctrl} = token_lookup(shreg_d);

        state_d     = state_q;
        run_ctr_d   = run_ctr_q;
        to_ctr_d    = to_ctr_q;
        slip_d      = 1'b0;
        sym_d       = sym_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        is_ctrl_d   = is_ctrl_q;
        sym_valid_d = 1'b0;
        publish     = 1'b0;
        run_inc     = (run_ctr_q == 8'hFF) ? run_ctr_q : run_ctr_q + 8'd1;
        to_inc      = (to_ctr_q == 16'hFFFF) ? to_ctr_q : to_ctr_q + 16'd1;

        if (slip_q) begin
            phase_d = phase_q;
        end else if (capture) begin
            phase_d = 4'd0;
        end else begin
            phase_d = phase_q + 4'd1;
        end

        if (!en) begin
            state_d   = ST_HUNT;
            run_ctr_d = 8'd0;
            to_ctr_d  = 16'd0;
        end else if (capture) begin
            case (state_q)
                ST_HUNT: begin
                    if (tok_hit) begin
                        run_ctr_d = run_inc;
                        if (run_inc >= RUN_LIM) begin
                            state_d  = ST_LOCKED;
                            to_ctr_d = 16'd0;
                            publish  = 1'b1;
                        end
                    end else begin
                        run_ctr_d = 8'd0;
                        slip_d    = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    publish = 1'b1;
                    if (tok_hit) begin
                        to_ctr_d = 16'd0;
                    end else if (to_inc >= TO_LIM) begin
                        state_d   = ST_HUNT;
                        run_ctr_d = 8'd0;
                        to_ctr_d  = 16'd0;
                    end else begin
                        to_ctr_d = to_inc;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Published outputs hold between strobes; ctrl only moves on tokens.
        if (publish) begin
            sym_valid_d = 1'b1;
            sym_d       = shreg_d;
            data_d      = tmds_decode(shreg_d);
            is_ctrl_d   = tok_hit;
            if (tok_hit) begin
                ctrl_d = tok_ctrl;
            end
        end
    end

    // State and datapath registers, all cleared asynchronously by reset.
    always_ff @(posedge clk_bit or negedge rst_n_bit) begin
        if (!rst_n_bit) begin
            state_q     <= ST_HUNT;
            shreg_q     <= 10'd0;
            phase_q     <= 4'd0;
            slip_q      <= 1'b0;
            run_ctr_q   <= 8'd0;
            to_ctr_q    <= 16'd0;
            sym_q       <= 10'd0;
            data_q      <= 8'd0;
            ctrl_q      <= 2'd0;
            is_ctrl_q   <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            phase_q     <= phase_d;
            slip_q      <= slip_d;
            run_ctr_q   <= run_ctr_d;
            to_ctr_q    <= to_ctr_d;
            sym_q       <= sym_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            is_ctrl_q   <= is_ctrl_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign data      = data_q;
    assign ctrl      = ctrl_q;
    assign is_ctrl   = is_ctrl_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tmds_rx_lane.sv
// -----------------------------------------------------------------------------
// tb_tmds_rx_lane
//
// Purpose:
//   Self-checking bench for tmds_rx_lane. A reference model tracks the
//   received bit history, works out on which edge the next capture happens,
//   and predicts lock, strobes and decodes per captured symbol. Each scenario
//   task drives its own stimulus and compares the DUT against the model or
//   against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_tmds_rx_lane;

    localparam int CTRL_RUN     = 8;
    localparam int TIMEOUT_SYMS = 1024;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic       clk_bit   = 1'b0;
    logic       rst_n_bit = 1'b0;
    logic       en        = 1'b0;
    logic       sdata     = 1'b0;
    logic       sym_valid;
    logic [9:0] sym;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       is_ctrl;
    logic       locked;

    int total = 0;
    int bad   = 0;

    tmds_rx_lane #(
        .CTRL_RUN    (CTRL_RUN),
        .TIMEOUT_SYMS(TIMEOUT_SYMS)
    ) dut (
        .clk_bit  (clk_bit),
        .rst_n_bit(rst_n_bit),
        .en       (en),
        .sdata    (sdata),
        .sym_valid(sym_valid),
        .sym      (sym),
        .data     (data),
        .ctrl     (ctrl),
        .is_ctrl  (is_ctrl),
        .locked   (locked)
    );

    always #5 clk_bit = ~clk_bit;

    // Reference model state.
    bit         hist[$];
    int         edgeCnt;
    int         nextCap;
    int         mRun;
    int         mTo;
    bit         mLocked;
    bit         mValid;
    logic [9:0] mSym;
    logic [7:0] mData;
    logic [1:0] mCtrl;
    bit         mIsCtrl;

    logic [22:0] dutVec;
    logic [22:0] refVec;
    assign dutVec = {locked, sym_valid, sym, data, ctrl, is_ctrl};
    assign refVec = {mLocked, mValid, mSym, mData, mCtrl, mIsCtrl};

    function automatic int tokenOf(input logic [9:0] w);
        case (w)
            C00:     return 0;
            C01:     return 1;
            C10:     return 2;
            C11:     return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] decodeRef(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d = w[9] ? ~w[7:0] : w[7:0];
        q = 8'h00;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (w[8]) q[i] = d[i] ^ d[i-1];
            else      q[i] = (d[i] == d[i-1]);
        end
        return q;
    endfunction

    function automatic logic [9:0] randData();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        while (tokenOf(w) >= 0) w = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    function automatic logic [9:0] randTok();
        logic [9:0] t[4];
        t[0] = C00; t[1] = C01; t[2] = C10; t[3] = C11;
        return t[$urandom_range(0, 3)];
    endfunction

    task automatic resetModel();
        hist.delete();
        edgeCnt = 0;
        nextCap = 10;
        mRun    = 0;
        mTo     = 0;
        mLocked = 0;
        mValid  = 0;
        mSym    = '0;
        mData   = '0;
        mCtrl   = '0;
        mIsCtrl = 0;
    endtask

    // Advances the model by one bit-clock edge with the given inputs.
    task automatic modelEdge(input bit b, input bit e);
        logic [9:0] w;
        int         t;
        bit         cap;
        edgeCnt++;
        hist.push_back(b);
        if (hist.size() > 20) void'(hist.pop_front());
        mValid = 0;
        cap    = (edgeCnt == nextCap);
        w      = '0;
        t      = -1;
        if (cap) begin
            for (int k = 0; k < 10; k++) w[k] = hist[hist.size() - 10 + k];
            t = tokenOf(w);
        end
        if (!e) begin
            mLocked = 0; mRun = 0; mTo = 0;
            if (cap) nextCap += 10;
        end else if (cap) begin
            if (!mLocked) begin
                if (t >= 0) begin
                    mRun    = (mRun < 255) ? mRun + 1 : 255;
                    nextCap += 10;
                    if (mRun >= CTRL_RUN) begin
                        mLocked = 1;
                        mTo     = 0;
                        mValid  = 1;
                    end
                end else begin
                    mRun    = 0;
                    nextCap += 11;
                end
            end else begin
                mValid  = 1;
                nextCap += 10;
                if (t >= 0) mTo = 0;
                else begin
                    mTo++;
                    if (mTo >= TIMEOUT_SYMS) begin
                        mLocked = 0; mRun = 0; mTo = 0;
                    end
                end
            end
            if (mValid) begin
                mSym    = w;
                mData   = decodeRef(w);
                mIsCtrl = (t >= 0);
                if (t >= 0) mCtrl = t[1:0];
            end
        end
    endtask

    task automatic step(input bit b);
        sdata = b;
        @(posedge clk_bit);
        modelEdge(b, en);
        #1;
    endtask

    task automatic test_reset();
        rst_n_bit = 1'b0;
        en        = 1'b0;
        sdata     = 1'b1;
        #12;
        total++;
        if (dutVec !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h expected %h", dutVec, 23'd0);
        end
        en = 1'b1;
        repeat (3) @(posedge clk_bit);
        #1;
        total++;
        if (dutVec !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_held: got %h expected %h", dutVec, 23'd0);
        end
        rst_n_bit = 1'b1;
        resetModel();
    endtask

    task automatic test_acquire();
        int lockEdge = -1;
        int edges    = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            edges++;
        end
        for (int s = 0; s < 20; s++) begin
            for (int k = 0; k < 10; k++) begin
                step(C00[k]);
                edges++;
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL acquire_cycle: got %h expected %h", dutVec, refVec);
                end
                if (locked === 1'b1 && lockEdge < 0) lockEdge = edges;
            end
        end
        total++;
        if (lockEdge != 113) begin
            bad++;
            $display("[TB] FAIL acquire_lock_edge: got %0d expected %0d", lockEdge, 113);
        end
        total++;
        if ({sym_valid, sym, ctrl, is_ctrl} !== {1'b1, C00, 2'b00, 1'b1}) begin
            bad++;
            $display("[TB] FAIL acquire_c00: got %h expected %h",
                     {sym_valid, sym, ctrl, is_ctrl}, {1'b1, C00, 2'b00, 1'b1});
        end
    endtask

    task automatic test_decode();
        logic [9:0] w;
        w = 10'b0100000000;
        for (int k = 0; k < 10; k++) begin
            step(w[k]);
            total++;
            if (dutVec !== refVec) begin
                bad++;
                $display("[TB] FAIL decode_cycle: got %h expected %h", dutVec, refVec);
            end
        end
        total++;
        if ({sym_valid, data, is_ctrl, ctrl} !== {1'b1, 8'h00, 1'b0, 2'b00}) begin
            bad++;
            $display("[TB] FAIL decode_zero: got %h expected %h",
                     {sym_valid, data, is_ctrl, ctrl}, {1'b1, 8'h00, 1'b0, 2'b00});
        end
        w = 10'b1011111111;
        for (int k = 0; k < 10; k++) begin
            step(w[k]);
            total++;
            if (dutVec !== refVec) begin
                bad++;
                $display("[TB] FAIL decode_cycle: got %h expected %h", dutVec, refVec);
            end
        end
        total++;
        if ({data, is_ctrl, ctrl} !== {8'hFE, 1'b0, 2'b00}) begin
            bad++;
            $display("[TB] FAIL decode_fe: got %h expected %h",
                     {data, is_ctrl, ctrl}, {8'hFE, 1'b0, 2'b00});
        end
        for (int s = 0; s < 12; s++) begin
            w = randData();
            for (int k = 0; k < 10; k++) begin
                step(w[k]);
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL decode_random: got %h expected %h", dutVec, refVec);
                end
            end
        end
    endtask

    task automatic test_ctrl_token();
        logic [9:0] w;
        for (int k = 0; k < 10; k++) step(C01[k]);
        total++;
        if ({sym_valid, ctrl, is_ctrl} !== {1'b1, 2'b01, 1'b1}) begin
            bad++;
            $display("[TB] FAIL ctrl_c01: got %h expected %h",
                     {sym_valid, ctrl, is_ctrl}, {1'b1, 2'b01, 1'b1});
        end
        for (int s = 0; s < 16; s++) begin
            w = ($urandom_range(0, 1) == 1) ? randTok() : randData();
            for (int k = 0; k < 10; k++) begin
                step(w[k]);
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL ctrl_mix: got %h expected %h", dutVec, refVec);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] w;
        for (int k = 0; k < 10; k++) step(C10[k]);
        for (int s = 0; s < TIMEOUT_SYMS - 1; s++) begin
            w = randData();
            for (int k = 0; k < 10; k++) begin
                step(w[k]);
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL timeout_run: got %h expected %h", dutVec, refVec);
                end
            end
        end
        for (int k = 0; k < 10; k++) step(C11[k]);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_1023_kept: got %b expected %b", locked, 1'b1);
        end
        for (int s = 0; s < TIMEOUT_SYMS; s++) begin
            w = randData();
            for (int k = 0; k < 10; k++) begin
                step(w[k]);
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL timeout_run: got %h expected %h", dutVec, refVec);
                end
            end
            if (s == TIMEOUT_SYMS - 2) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL timeout_early: got %b expected %b", locked, 1'b1);
                end
            end
        end
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_drop: got %b expected %b", locked, 1'b0);
        end
        for (int s = 0; s < CTRL_RUN; s++) begin
            w = randTok();
            for (int k = 0; k < 10; k++) step(w[k]);
            total++;
            if (s < CTRL_RUN - 1 && {locked, sym_valid} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL timeout_hunt_quiet: got %b expected %b", {locked, sym_valid}, 2'b00);
            end else if (s == CTRL_RUN - 1 && {locked, sym_valid} !== 2'b11) begin
                bad++;
                $display("[TB] FAIL timeout_relock: got %b expected %b", {locked, sym_valid}, 2'b11);
            end
        end
    endtask

    task automatic test_enable();
        for (int k = 0; k < 10; k++) begin
            if (k == 9) en = 1'b0;
            step(C00[k]);
            en = 1'b1;
        end
        total++;
        if ({locked, sym_valid} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL enable_drop: got %b expected %b", {locked, sym_valid}, 2'b00);
        end
        for (int s = 0; s < CTRL_RUN; s++) begin
            for (int k = 0; k < 10; k++) begin
                step(C01[k]);
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL enable_cycle: got %h expected %h", dutVec, refVec);
                end
            end
            if (s == CTRL_RUN - 2) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL enable_early_lock: got %b expected %b", locked, 1'b0);
                end
            end
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("[TB] FAIL enable_relock: got %b expected %b", locked, 1'b1);
        end
    endtask

    task automatic test_reset_midlock();
        for (int k = 0; k < 4; k++) step(C10[k]);
        #2;
        rst_n_bit = 1'b0;
        #1;
        total++;
        if (dutVec !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_async: got %h expected %h", dutVec, 23'd0);
        end
        @(posedge clk_bit);
        #1;
        rst_n_bit = 1'b1;
        resetModel();
        for (int s = 0; s < CTRL_RUN; s++) begin
            for (int k = 0; k < 10; k++) begin
                step(C10[k]);
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL reset_relock_cycle: got %h expected %h", dutVec, refVec);
                end
            end
            if (s == CTRL_RUN - 2) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL reset_early_lock: got %b expected %b", locked, 1'b0);
                end
            end
        end
        total++;
        if ({locked, sym_valid, ctrl} !== {1'b1, 1'b1, 2'b10}) begin
            bad++;
            $display("[TB] FAIL reset_relock: got %b expected %b",
                     {locked, sym_valid, ctrl}, {1'b1, 1'b1, 2'b10});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w;
        int         dropAt;
        for (int s = 0; s < 80; s++) begin
            w      = ($urandom_range(0, 3) != 0) ? randTok() : randData();
            dropAt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 9)) : -1;
            for (int k = 0; k < 10; k++) begin
                if (k == dropAt) en = 1'b0;
                step(w[k]);
                en = 1'b1;
                total++;
                if (dutVec !== refVec) begin
                    bad++;
                    $display("[TB] FAIL back_to_back: got %h expected %h", dutVec, refVec);
                end
            end
        end
    endtask

    initial begin
        resetModel();
        test_reset();
        test_acquire();
        test_decode();
        test_ctrl_token();
        test_timeout();
        test_enable();
        test_reset_midlock();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
